// File: rtl/dc_fu_dma_mc_addr_gen.sv
// Multi-channel round-robin AXI read-address generator, one outstanding request.
// Define DC_FU_DMA_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module dc_fu_dma_mc_addr_gen #(
  parameter int NUM_CH                 = 2,
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int AXI_ARADDR_WIDTH       = 32,
  parameter int MAX_BURST_LEN          = 4,
  parameter int READ_DATA_SIZE         = 1,
  localparam int ID_W                  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic [NUM_CH-1:0]                        start_fetch,
  input  logic [NUM_CH*FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
  input  logic [NUM_CH*AXI_ARADDR_WIDTH-1:0]       base_addr,
  output logic                                     axi_arvalid,
  input  logic                                     axi_arready,
  output logic [AXI_ARADDR_WIDTH-1:0]              axi_araddr,
  output logic [7:0]                               axi_arlen,
  output logic [ID_W-1:0]                          axi_arid,
  output logic [NUM_CH-1:0]                        ch_busy,
  output logic [NUM_CH-1:0]                        ch_done
);

  localparam int FW = FETCH_WORD_COUNT_WIDTH;
  localparam int AW = AXI_ARADDR_WIDTH;
  localparam int CW = (FW > 13) ? FW : 13;
  localparam logic [CW-1:0] MAX_BEATS  = CW'(1) << MAX_BURST_LEN;
  localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << READ_DATA_SIZE) - AW'(1));

  typedef enum logic {AR_IDLE, AR_VALID} ar_state_e;

  ar_state_e         ar_state_q, ar_state_d;
  logic [NUM_CH-1:0] ch_active_q, ch_done_q;
  logic [FW-1:0]     rem_q  [NUM_CH];
  logic [AW-1:0]     addr_q [NUM_CH];
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_next, gnt_id, cand;
  logic              gnt_found;
  logic [CW-1:0]     gnt_beats;
  logic [AW-1:0]     araddr_q;
  logic [7:0]        arlen_q;
  logic [ID_W-1:0]   arid_q;
  logic              hs;
  logic [8:0]        hs_beats;
  logic [AW-1:0]     hs_incr;
  logic [FW-1:0]     hs_dec;

  // Round-robin search beginning one past the previous grant.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!gnt_found && ch_active_q[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    rr_ptr_next = ID_W'((int'(gnt_id) + 1) % NUM_CH);
  end

`ifdef DC_FU_DMA_4K_SPLIT_EN
  logic [CW-1:0] lim_4k;
  assign lim_4k = CW'((13'h1000 - {1'b0, addr_q[gnt_id][11:0]}) >> READ_DATA_SIZE);
`endif

  always_comb begin
    gnt_beats = CW'(rem_q[gnt_id]);
    if (gnt_beats > MAX_BEATS) gnt_beats = MAX_BEATS;
`ifdef DC_FU_DMA_4K_SPLIT_EN
    if (gnt_beats > lim_4k) gnt_beats = lim_4k;
`endif
  end

  assign hs       = (ar_state_q == AR_VALID) && axi_arready;
  assign hs_beats = {1'b0, arlen_q} + 9'd1;
  assign hs_incr  = AW'(hs_beats) << READ_DATA_SIZE;
  assign hs_dec   = FW'(hs_beats);

  // Request FSM: state register, next state, outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) ar_state_q <= AR_IDLE;
    else     ar_state_q <= ar_state_d;
  end

  always_comb begin
    ar_state_d = ar_state_q;
    case (ar_state_q)
      AR_IDLE:  if (en && gnt_found) ar_state_d = AR_VALID;
      AR_VALID: if (axi_arready)     ar_state_d = AR_IDLE;
      default:                       ar_state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    axi_arvalid = (ar_state_q == AR_VALID);
  end

  // Request fields are captured at grant and held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      rr_ptr_q <= '0;
    end else if (ar_state_q == AR_IDLE && en && gnt_found) begin
      araddr_q <= addr_q[gnt_id];
      arlen_q  <= 8'(gnt_beats - CW'(1));
      arid_q   <= gnt_id;
      rr_ptr_q <= rr_ptr_next;
    end
  end

  // Per-channel bookkeeping; a handshake and a start on different channels coexist.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_active_q <= '0;
      ch_done_q   <= '0;
      // NOTE: these small flop arrays are cleared on reset; they are registers, not RAM.
      for (int i = 0; i < NUM_CH; i++) begin
        rem_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      ch_done_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (hs && arid_q == ID_W'(i)) begin
          addr_q[i] <= addr_q[i] + hs_incr;
          rem_q[i]  <= rem_q[i] - hs_dec;
          if (rem_q[i] == hs_dec) begin
            ch_active_q[i] <= 1'b0;
            ch_done_q[i]   <= 1'b1;
          end
        end else if (en && start_fetch[i] && !ch_active_q[i]) begin
          if (fetch_word_count[i*FW +: FW] == '0) begin
            ch_done_q[i] <= 1'b1;
          end else begin
            rem_q[i]       <= fetch_word_count[i*FW +: FW];
            addr_q[i]      <= base_addr[i*AW +: AW] & ALIGN_MASK;
            ch_active_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign axi_araddr = araddr_q;
  assign axi_arlen  = arlen_q;
  assign axi_arid   = arid_q;
  assign ch_busy    = ch_active_q;
  assign ch_done    = ch_done_q;

endmodule

// File: tb/tb_dc_fu_dma_mc_addr_gen.sv
// Self-checking bench for dc_fu_dma_mc_addr_gen: directed cases plus random traffic
// checked against a per-channel expected-burst list model.
module tb_dc_fu_dma_mc_addr_gen;

  localparam int NUM_CH = 2;
  localparam int FWCW   = 16;
  localparam int AW     = 32;
  localparam int MBL    = 4;
  localparam int RDS    = 1;
  localparam int IDW    = 1;

  logic                   clk = 1'b0;
  logic                   rst, en, axi_arready;
  logic [NUM_CH-1:0]      start_fetch;
  logic [NUM_CH*FWCW-1:0] fetch_word_count;
  logic [NUM_CH*AW-1:0]   base_addr;
  logic                   axi_arvalid;
  logic [AW-1:0]          axi_araddr;
  logic [7:0]             axi_arlen;
  logic [IDW-1:0]         axi_arid;
  logic [NUM_CH-1:0]      ch_busy, ch_done;

  dc_fu_dma_mc_addr_gen #(
    .NUM_CH(NUM_CH), .FETCH_WORD_COUNT_WIDTH(FWCW), .AXI_ARADDR_WIDTH(AW),
    .MAX_BURST_LEN(MBL), .READ_DATA_SIZE(RDS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start_fetch(start_fetch),
    .fetch_word_count(fetch_word_count), .base_addr(base_addr),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arid(axi_arid), .ch_busy(ch_busy), .ch_done(ch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          id;
    int          cyc;
  } hs_t;

  int                total = 0;
  int                bad   = 0;
  int                cyc   = 0;
  logic [39:0]       expq [NUM_CH][$];   // {addr, len} still owed per channel
  logic [NUM_CH-1:0] m_busy = '0;
  hs_t               hs_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Split a fetch into bursts straight from the burst-size rules.
  task automatic add_bursts(input int ch, input int cnt, input logic [31:0] base);
    logic [31:0] a;
    int          rem, b;
    a   = base & ~((32'd1 << RDS) - 32'd1);
    rem = cnt;
    while (rem > 0) begin
      b = (rem < (1 << MBL)) ? rem : (1 << MBL);
`ifdef DC_FU_DMA_4K_SPLIT_EN
      if (b > ((4096 - int'(a[11:0])) >> RDS)) b = (4096 - int'(a[11:0])) >> RDS;
`endif
      expq[ch].push_back({a, 8'(b - 1)});
      a   = a + (32'(b) << RDS);
      rem = rem - b;
    end
  endtask

  task automatic set_ch(input int ch, input int cnt, input logic [31:0] base);
    fetch_word_count[ch*FWCW +: FWCW] = FWCW'(cnt);
    base_addr[ch*AW +: AW]            = base;
    start_fetch[ch]                   = 1'b1;
  endtask

  // One clock: apply the model to what was presented before the edge, then compare.
  task automatic tick();
    logic                   pv, pr, prst, pen;
    logic [NUM_CH-1:0]      pst, exp_done;
    logic [NUM_CH*FWCW-1:0] pcnt;
    logic [NUM_CH*AW-1:0]   pbase;
    logic [31:0]            pa;
    logic [7:0]             pl;
    logic [IDW-1:0]         pid;
    logic [39:0]            head;
    int                     cnt;
    pv = axi_arvalid; pr = axi_arready; prst = rst; pen = en; pst = start_fetch;
    pcnt = fetch_word_count; pbase = base_addr;
    pa = axi_araddr; pl = axi_arlen; pid = axi_arid;
    @(posedge clk);
    #1;
    cyc++;
    exp_done = '0;
    if (prst) begin
      m_busy = '0;
      for (int i = 0; i < NUM_CH; i++) expq[i].delete();
      chk("rst_arvalid", axi_arvalid, 0);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pv && pr && int'(pid) == i) begin
          chk("hs_expected", expq[i].size() != 0, 1);
          if (expq[i].size() != 0) begin
            head = expq[i].pop_front();
            chk("hs_addr", pa, head[39:8]);
            chk("hs_len", pl, head[7:0]);
            if (expq[i].size() == 0) begin
              m_busy[i]   = 1'b0;
              exp_done[i] = 1'b1;
            end
          end
          hs_log.push_back('{pa, i, cyc});
        end else if (pen && pst[i] && !m_busy[i]) begin
          cnt = int'(pcnt[i*FWCW +: FWCW]);
          if (cnt == 0) exp_done[i] = 1'b1;
          else begin
            m_busy[i] = 1'b1;
            add_bursts(i, cnt, pbase[i*AW +: AW]);
          end
        end
      end
      if (pv && !pr) begin
        chk("stall_valid", axi_arvalid, 1);
        chk("stall_addr", axi_araddr, pa);
        chk("stall_len", axi_arlen, pl);
        chk("stall_id", axi_arid, pid);
      end
    end
    chk("busy", ch_busy, m_busy);
    chk("done", ch_done, exp_done);
    start_fetch = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_busy != '0 || axi_arvalid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_arlen", axi_arlen, 0);
    chk("rst_arid", axi_arid, 0);
    hs_log.delete();
  endtask

  initial begin
    logic [31:0] ea [4];
    int          eid [4];
    rst = 1'b1; en = 1'b1; axi_arready = 1'b0;
    start_fetch = '0; fetch_word_count = '0; base_addr = '0;

    // Reset state
    do_reset();

    // Single channel, count 40: latency, 5-cycle stall, burst split, back-to-back spacing
    set_ch(0, 40, 32'h1000);
    tick();
    chk("lat_cycle1_idle", axi_arvalid, 0);
    tick();
    chk("lat_cycle2_valid", axi_arvalid, 1);
    chk("first_addr", axi_araddr, 32'h1000);
    chk("first_len", axi_arlen, 15);
    chk("first_id", axi_arid, 0);
    for (int i = 0; i < 5; i++) tick();
    axi_arready = 1'b1;
    drain(50);
    chk("c40_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("c40_addr1", hs_log[1].addr, 32'h1020);
      chk("c40_addr2", hs_log[2].addr, 32'h1040);
      chk("c40_gap1", hs_log[1].cyc - hs_log[0].cyc, 2);
      chk("c40_gap2", hs_log[2].cyc - hs_log[1].cyc, 2);
    end

    // Two channels started together: round-robin interleave
    do_reset();
    set_ch(0, 32, 32'h0);
    set_ch(1, 32, 32'h8000);
    tick();
    drain(50);
    ea  = '{32'h0, 32'h8000, 32'h20, 32'h8020};
    eid = '{0, 1, 0, 1};
    chk("rr_count", hs_log.size(), 4);
    if (hs_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_addr", hs_log[i].addr, ea[i]);
        chk("rr_id", hs_log[i].id, eid[i]);
      end
    end

    // Burst near a 4 KB boundary
    do_reset();
    set_ch(1, 16, 32'h0FF0);
    tick();
    drain(50);
`ifdef DC_FU_DMA_4K_SPLIT_EN
    chk("page_count", hs_log.size(), 2);
    if (hs_log.size() == 2) chk("page_addr1", hs_log[1].addr, 32'h1000);
`else
    chk("page_count", hs_log.size(), 1);
`endif

    // Zero-length fetch
    do_reset();
    set_ch(0, 0, 32'h400);
    tick();
    chk("zero_done", ch_done, 2'b01);
    chk("zero_novalid", axi_arvalid, 0);
    tick();
    tick();
    chk("zero_novalid_later", axi_arvalid, 0);
    chk("zero_no_hs", hs_log.size(), 0);

    // Enable low: starts ignored, pending request still completes
    do_reset();
    axi_arready = 1'b0;
    en = 1'b0;
    set_ch(0, 8, 32'h40);
    tick();
    chk("en0_ignored", ch_busy, 0);
    en = 1'b1;
    set_ch(0, 8, 32'h40);
    tick();
    tick();
    chk("en_valid", axi_arvalid, 1);
    en = 1'b0;
    tick();
    tick();
    axi_arready = 1'b1;
    tick();
    chk("en0_hs_completes", hs_log.size(), 1);
    en = 1'b1;
    drain(20);

    // Reset while a request is pending
    do_reset();
    axi_arready = 1'b0;
    set_ch(0, 64, 32'h0);
    tick();
    tick();
    chk("midrst_valid_before", axi_arvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", axi_arvalid, 0);
    chk("midrst_busy", ch_busy, 0);
    chk("midrst_done", ch_done, 0);
    tick();
    chk("midrst_done_after", ch_done, 0);
    chk("midrst_valid_after", axi_arvalid, 0);

    // Random traffic: starts (some while busy), stalls, enable gaps
    do_reset();
    for (int n = 0; n < 600; n++) begin
      en          = ($urandom_range(0, 7) != 0);
      axi_arready = 1'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) set_ch(c, $urandom_range(0, 70), $urandom);
      end
      tick();
    end
    en = 1'b1;
    axi_arready = 1'b1;
    drain(2000);
    for (int c = 0; c < NUM_CH; c++) chk("rand_all_issued", expq[c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dc_fu_dma_mc_addr_gen.md
DC_FU_DMA_MC_ADDR_GEN -- requirements
Module: dc_fu_dma_mc_addr_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent fetch channels, 1..8.
REQ-002 SHALL have parameter FETCH_WORD_COUNT_WIDTH, default 16: width of the per-channel word count.
REQ-003 SHALL have parameter AXI_ARADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 4: log2 of the maximum beats per burst, 0..8.
REQ-005 SHALL have parameter READ_DATA_SIZE, default 1: log2 of the bytes per beat.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-008 SHALL have port en, input, 1 bit: global enable.
REQ-009 SHALL have port start_fetch, input, NUM_CH bits: per-channel start pulse.
REQ-010 SHALL have port fetch_word_count, input, NUM_CH*FETCH_WORD_COUNT_WIDTH bits: per-channel total beats.
REQ-011 SHALL have port base_addr, input, NUM_CH*AXI_ARADDR_WIDTH bits: per-channel start byte address.
REQ-012 SHALL have port axi_arvalid, output, 1 bit: request valid.
REQ-013 SHALL have port axi_arready, input, 1 bit: request accepted.
REQ-014 SHALL have port axi_araddr, output, AXI_ARADDR_WIDTH bits: burst address.
REQ-015 SHALL have port axi_arlen, output, 8 bits: beats minus 1.
REQ-016 SHALL have port axi_arid, output, max(1,$clog2(NUM_CH)) bits: index of the owning channel.
REQ-017 SHALL have port ch_busy, output, NUM_CH bits: channel has words outstanding.
REQ-018 SHALL have port ch_done, output, NUM_CH bits: one-cycle pulse when the channel's last burst is accepted.

Function
REQ-019 Each channel SHALL hold a remaining-words counter and a current-address register, and SHALL be in state IDLE or ACTIVE.
REQ-020 start_fetch[i] in IDLE with en=1 SHALL load the remaining count and the address (base_addr with its low READ_DATA_SIZE bits forced to 0) and set ACTIVE; start_fetch[i] while ACTIVE SHALL be ignored.
REQ-021 start_fetch[i] with a count of 0 SHALL leave the channel IDLE and pulse ch_done[i] on the next cycle, with no request issued.
REQ-022 The request FSM SHALL have two states, AR_IDLE and AR_VALID, and SHALL allow only one outstanding request.
REQ-023 In AR_IDLE with en=1 and at least one channel ACTIVE, the FSM SHALL grant round-robin, starting the search at the index after the last grant (channel 0 after reset), register axi_araddr, axi_arlen and axi_arid, and enter AR_VALID.
REQ-024 Burst beats SHALL be min(remaining, 2**MAX_BURST_LEN), further limited per REQ-034 when that feature is compiled in.
REQ-025 In AR_VALID, axi_arvalid SHALL be 1 and axi_araddr, axi_arlen and axi_arid SHALL stay stable until axi_arvalid && axi_arready.
REQ-026 On a handshake, the owning channel's address SHALL advance by beats<<READ_DATA_SIZE (modulo 2**AXI_ARADDR_WIDTH), its remaining count SHALL drop by beats, and the FSM SHALL return to AR_IDLE.
REQ-027 If remaining reaches 0 on a handshake, the channel SHALL go IDLE, ch_busy[i] SHALL fall, and ch_done[i] SHALL pulse on the following cycle.
REQ-028 Latency from start_fetch at cycle N to the first axi_arvalid SHALL be exactly N+2 when the FSM is in AR_IDLE; back-to-back requests SHALL occupy at most 2 cycles each (handshake cycle, then a registered grant).
REQ-029 en=0 SHALL freeze channel starts and grants; a request already in AR_VALID SHALL stay asserted and its handshake SHALL complete normally.
REQ-030 A start on one channel in the same cycle as a handshake on another SHALL be processed for both.
REQ-031 ch_busy[i] SHALL equal (state==ACTIVE).

Reset
REQ-032 rst=1 SHALL, on the next clock edge, clear all channels to IDLE with remaining=0 and address=0, set the FSM to AR_IDLE and the round-robin pointer to 0, and drive axi_arvalid, axi_araddr, axi_arlen, axi_arid, ch_busy and ch_done to 0.
REQ-033 Reset in mid-operation SHALL abandon all pending requests with no ch_done pulse.

Configuration
REQ-034 With DC_FU_DMA_4K_SPLIT_EN defined, beats SHALL also be limited to (4096 - addr[11:0])>>READ_DATA_SIZE so that no burst crosses a 4 KB boundary; without it, no boundary check SHALL exist and bursts SHALL be limited only by REQ-024.

Verification
REQ-035 Channel 0 with count 40 and base 0x1000 SHALL produce requests (0x1000, len 15), (0x1020, len 15), (0x1040, len 7), all with id 0, and one ch_done[0] pulse after the third handshake.
REQ-036 Both channels started in the same cycle with count 32 each (bases 0x0 and 0x8000) and arready=1 SHALL produce ids 0,1,0,1 with addresses 0x0, 0x8000, 0x20, 0x8020.
REQ-037 arready held at 0 for 5 cycles during a request SHALL leave axi_arvalid, axi_araddr, axi_arlen and axi_arid unchanged over those cycles.
REQ-038 Base 0x0FF0 with count 16 SHALL produce (0xFF0, len 7) then (0x1000, len 7) with the macro defined, and a single (0xFF0, len 15) without it.
REQ-039 A count of 0 SHALL give a ch_done pulse one cycle later and no axi_arvalid.
REQ-040 rst asserted while axi_arvalid=1 SHALL give axi_arvalid=0 and ch_busy=0 after the next edge, with no ch_done pulse.
